// File: rtl/pio_pkg.sv
// Shared definitions for the PIO command sequencer: action codes, config-entry
// field positions and the sequencer state encoding.
package pio_pkg;

    localparam logic [5:0] ACT_NONE  = 6'd0;
    localparam logic [5:0] ACT_INSTR = 6'd1;
    localparam logic [5:0] ACT_PUSH  = 6'd4;
    localparam logic [5:0] ACT_PULL  = 6'd5;

    // Config ROM entry layout: {mindex, action, din}
    localparam int CONF_MIDX_HI = 37;
    localparam int CONF_MIDX_LO = 36;
    localparam int CONF_ACT_HI  = 35;
    localparam int CONF_ACT_LO  = 32;
    localparam int CONF_DIN_HI  = 31;
    localparam int CONF_DIN_LO  = 0;

    typedef enum logic [2:0] {
        PROG,
        CONF,
        GAP,
        RUN,
        PULLW
    } seq_state_t;

endpackage

// File: rtl/pio_sequencer_rr_arb4.sv
// Four-way combinational round-robin arbiter; search starts at i_ptr and wraps.
// The pointer register is owned by the caller.
module rr_arb4 (
    input  logic [3:0] i_eligible,
    input  logic [1:0] i_ptr,
    output logic [3:0] o_grant,
    output logic       o_valid
);

    always_comb begin
        logic [1:0] w_idx;
        o_grant = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < 4; k++) begin
            w_idx = i_ptr + 2'(k);
            if (!o_valid && i_eligible[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pio_sequencer.sv
// Owns the PIO command bus: streams instruction and config ROMs after reset,
// then round-robin arbitrates client TX pushes and RX pulls.
//
// state | meaning
// PROG  | pipelined instruction ROM load, one ACT_INSTR per cycle
// CONF  | pipelined config ROM replay, one action per entry
// GAP   | one idle command cycle, din held, then RUN
// RUN   | arbitrate clients; push -> GAP, pull -> PULLW
// PULLW | PIO read data on dout is handed to the pulling client
module pio_sequencer
    import pio_pkg::*;
#(
    parameter int PROG_LEN = 32,
    parameter int CONF_LEN = 5
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         reload,
    output logic [4:0]   prog_addr,
    input  logic [15:0]  prog_data,
    output logic [4:0]   conf_addr,
    input  logic [37:0]  conf_data,
    output logic [5:0]   action,
    output logic [31:0]  din,
    output logic [4:0]   index,
    output logic [1:0]   mindex,
    input  logic [31:0]  dout,
    input  logic [3:0]   tx_full,
    input  logic [3:0]   rx_empty,
    input  logic [3:0]   push_req,
    input  logic [127:0] push_data,
    output logic [3:0]   push_ack,
    input  logic [3:0]   pull_req,
    output logic [3:0]   pull_valid,
    output logic [31:0]  pull_data,
    output logic         loaded
);

    localparam logic [5:0] PROG_END = 6'(PROG_LEN);
    localparam logic [5:0] CONF_END = 6'(CONF_LEN);

    seq_state_t  r_state, w_state;
    logic [5:0]  r_cnt, w_cnt;
    logic [1:0]  r_ptr, w_ptr;
    logic [1:0]  r_pull_sel, w_pull_sel;
    logic        r_reload_pend, w_reload_pend;
    logic        r_loaded, w_loaded;
    logic [31:0] r_din;

    logic [3:0]  w_push_ok;
    logic [3:0]  w_pull_ok;
    logic [3:0]  w_grant;
    logic        w_grant_vld;
    logic [1:0]  w_gidx;

    assign w_push_ok = push_req & ~tx_full;
    assign w_pull_ok = pull_req & ~rx_empty;
    assign loaded    = r_loaded;

    rr_arb4 u_arb (
        .i_eligible (w_push_ok | w_pull_ok),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_valid    (w_grant_vld)
    );

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < 4; i++) begin
            if (w_grant[i]) w_gidx = 2'(i);
        end
    end

    // r_cnt holds the address presented this cycle; word r_cnt-1 is on the data bus.
    always_comb begin
        w_state       = r_state;
        w_cnt         = r_cnt;
        w_ptr         = r_ptr;
        w_pull_sel    = r_pull_sel;
        w_reload_pend = r_reload_pend;
        w_loaded      = r_loaded;
        action        = ACT_NONE;
        din           = r_din;
        index         = '0;
        mindex        = '0;
        push_ack      = '0;
        pull_valid    = '0;
        pull_data     = '0;
        prog_addr     = '0;
        conf_addr     = '0;

        case (r_state)
            PROG: begin
                prog_addr = r_cnt[4:0];
                if (r_cnt != 6'd0) begin
                    action = ACT_INSTR;
                    index  = 5'(r_cnt - 6'd1);
                    din    = {16'h0, prog_data};
                end
                if (r_cnt == PROG_END) begin
                    if (CONF_LEN == 0) begin
                        w_state  = RUN;
                        w_cnt    = '0;
                        w_loaded = 1'b1;
                    end else begin
                        // present config address 0 now so CONF issues without a bubble
                        conf_addr = 5'd0;
                        w_state   = CONF;
                        w_cnt     = 6'd1;
                    end
                end else begin
                    w_cnt = r_cnt + 6'd1;
                end
            end

            CONF: begin
                conf_addr = r_cnt[4:0];
                action    = {2'b00, conf_data[CONF_ACT_HI:CONF_ACT_LO]};
                mindex    = conf_data[CONF_MIDX_HI:CONF_MIDX_LO];
                din       = conf_data[CONF_DIN_HI:CONF_DIN_LO];
                if (r_cnt == CONF_END) begin
                    w_state = GAP;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + 6'd1;
                end
            end

            GAP: begin
                if (reload) w_reload_pend = 1'b1;
                w_state  = RUN;
                w_loaded = 1'b1;
            end

            RUN: begin
                if (reload || r_reload_pend) begin
                    w_state       = PROG;
                    w_cnt         = '0;
                    w_loaded      = 1'b0;
                    w_reload_pend = 1'b0;
                end else if (w_grant_vld) begin
                    w_ptr  = w_gidx + 2'd1;
                    mindex = w_gidx;
                    if (w_push_ok[w_gidx]) begin
                        action   = ACT_PUSH;
                        din      = push_data[{w_gidx, 5'b00000} +: 32];
                        push_ack = w_grant;
                        w_state  = GAP;
                    end else begin
                        action     = ACT_PULL;
                        w_pull_sel = w_gidx;
                        w_state    = PULLW;
                    end
                end
            end

            PULLW: begin
                pull_data  = dout;
                pull_valid = 4'b0001 << r_pull_sel;
                w_state    = RUN;
            end

            default: begin
                w_state = PROG;
                w_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state       <= PROG;
            r_cnt         <= '0;
            r_ptr         <= '0;
            r_pull_sel    <= '0;
            r_reload_pend <= 1'b0;
            r_loaded      <= 1'b0;
            r_din         <= '0;
        end else begin
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_ptr         <= w_ptr;
            r_pull_sel    <= w_pull_sel;
            r_reload_pend <= w_reload_pend;
            r_loaded      <= w_loaded;
            r_din         <= din;
        end
    end

endmodule

// File: tb/tb_pio_sequencer.sv
// Directed bench for pio_sequencer: ROM load, reset/reload, round-robin pushes,
// backpressure and RX pulls, with hand-computed expectations.
module tb_pio_sequencer;

    logic         clk = 1'b0;
    logic         n_reset;
    logic         reload;
    logic [4:0]   prog_addr;
    logic [15:0]  prog_data;
    logic [4:0]   conf_addr;
    logic [37:0]  conf_data;
    logic [5:0]   action;
    logic [31:0]  din;
    logic [4:0]   index;
    logic [1:0]   mindex;
    logic [31:0]  dout;
    logic [3:0]   tx_full;
    logic [3:0]   rx_empty;
    logic [3:0]   push_req;
    logic [127:0] push_data;
    logic [3:0]   push_ack;
    logic [3:0]   pull_req;
    logic [3:0]   pull_valid;
    logic [31:0]  pull_data;
    logic         loaded;

    logic [15:0]  prog_rom [32];
    logic [37:0]  conf_rom [32];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        prog_data <= prog_rom[prog_addr];
        conf_data <= conf_rom[conf_addr];
    end

    pio_sequencer #(.PROG_LEN(32), .CONF_LEN(5)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .reload     (reload),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .conf_addr  (conf_addr),
        .conf_data  (conf_data),
        .action     (action),
        .din        (din),
        .index      (index),
        .mindex     (mindex),
        .dout       (dout),
        .tx_full    (tx_full),
        .rx_empty   (rx_empty),
        .push_req   (push_req),
        .push_data  (push_data),
        .push_ack   (push_ack),
        .pull_req   (pull_req),
        .pull_valid (pull_valid),
        .pull_data  (pull_data),
        .loaded     (loaded)
    );

    // Every observable output concatenated; all zero under reset.
    function automatic logic [127:0] all_outs();
        return {action, din, index, mindex, prog_addr, conf_addr,
                push_ack, pull_valid, pull_data, loaded};
    endfunction

    task automatic test_reset();
        n_reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (all_outs() !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_values got %h expected 0", all_outs());
        end
        n_reset = 1'b1;
    endtask

    task automatic test_mid_reset();
        logic seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (action === 6'd1 && index === 5'd10) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL mid_reset_reach_idx10 got not-seen expected seen");
        end
        #1 n_reset = 1'b0;
        #1;
        n_checks++;
        if (all_outs() !== 128'h0) begin
            n_fail++;
            $display("FAIL async_reset got %h expected 0", all_outs());
        end
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    // Entered at the negedge of the first cycle with address 0 presented.
    task automatic test_load();
        logic [44:0] got, exp;
        n_checks++;
        if ({action, loaded, prog_addr} !== 12'h0) begin
            n_fail++;
            $display("FAIL load_cycle0 got act=%0d loaded=%0d addr=%0d expected 0/0/0",
                     action, loaded, prog_addr);
        end
        for (int c = 1; c <= 39; c++) begin
            @(negedge clk);
            got = {action, index, mindex, din};
            if (c <= 32) begin
                exp = {6'd1, 5'(c - 1), 2'd0, 32'h0000A000 + 32'(c - 1)};
            end else if (c <= 37) begin
                exp = {6'(c - 33 + 2), 5'd0, 2'(c - 33), 32'hC0F00000 | 32'(c - 33)};
            end else begin
                exp = {6'd0, 5'd0, 2'd0, 32'hC0F00004};
            end
            n_checks++;
            if (got !== exp || loaded !== (c == 39)) begin
                n_fail++;
                $display("FAIL load_cycle%0d got cmd=%h loaded=%0d expected cmd=%h loaded=%0d",
                         c, got, loaded, exp, (c == 39));
            end
        end
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) push_data[32*i +: 32] = 32'hAB000000 + 32'(i);
        push_req = 4'hF;
        for (int g = 0; g < 5; g++) begin
            #1;
            n_checks++;
            if ({push_ack, action, mindex, din} !==
                {4'b0001 << order[g], 6'd4, 2'(order[g]), 32'hAB000000 + 32'(order[g])}) begin
                n_fail++;
                $display("FAIL rr_grant%0d got ack=%b act=%0d idx=%0d din=%h expected client %0d",
                         g, push_ack, action, mindex, din, order[g]);
            end
            @(negedge clk);
            n_checks++;
            if (push_ack !== 4'b0 || action !== 6'd0) begin
                n_fail++;
                $display("FAIL rr_gap%0d got ack=%b act=%0d expected 0/0", g, push_ack, action);
            end
            @(negedge clk);
        end
        push_req = 4'h0;
    endtask

    task automatic test_single_push();
        push_data[31:0] = 32'h1;
        push_req = 4'b0001;
        #1;
        n_checks++;
        if ({push_ack, action, mindex, din} !== {4'b0001, 6'd4, 2'd0, 32'h1}) begin
            n_fail++;
            $display("FAIL single_push got ack=%b act=%0d idx=%0d din=%h expected 0001/4/0/1",
                     push_ack, action, mindex, din);
        end
        @(negedge clk);
        push_req = 4'b0000;
        #1;
        n_checks++;
        if (push_ack !== 4'b0 || action !== 6'd0) begin
            n_fail++;
            $display("FAIL single_push_after got ack=%b act=%0d expected 0/0", push_ack, action);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic seen = 1'b0;
        push_data[95:64] = 32'h5A5A0002;
        tx_full  = 4'b0100;
        push_req = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_checks++;
            if (push_ack !== 4'b0 || action !== 6'd0) begin
                n_fail++;
                $display("FAIL backpressure_c%0d got ack=%b act=%0d expected 0/0", c, push_ack, action);
            end
            @(negedge clk);
        end
        tx_full = 4'b0000;
        for (int w = 0; w < 3 && !seen; w++) begin
            #1;
            if (push_ack === 4'b0100) seen = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (!seen || din !== 32'h5A5A0002 || mindex !== 2'd2) begin
            n_fail++;
            $display("FAIL backpressure_release got seen=%0d din=%h idx=%0d expected 1/5a5a0002/2",
                     seen, din, mindex);
        end
        @(negedge clk);
        push_req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_pull();
        rx_empty = 4'b1101;
        pull_req = 4'b0010;
        dout     = 32'hDEADBEEF;
        #1;
        n_checks++;
        if ({action, mindex, pull_valid, push_ack} !== {6'd5, 2'd1, 4'b0, 4'b0}) begin
            n_fail++;
            $display("FAIL pull_issue got act=%0d idx=%0d pv=%b ack=%b expected 5/1/0000/0000",
                     action, mindex, pull_valid, push_ack);
        end
        @(negedge clk);
        pull_req = 4'b0000;
        #1;
        n_checks++;
        if ({action, pull_valid, pull_data} !== {6'd0, 4'b0010, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL pull_data got act=%0d pv=%b data=%h expected 0/0010/deadbeef",
                     action, pull_valid, pull_data);
        end
        @(negedge clk);
        n_checks++;
        if (pull_valid !== 4'b0 || pull_data !== 32'h0) begin
            n_fail++;
            $display("FAIL pull_after got pv=%b data=%h expected 0000/0", pull_valid, pull_data);
        end
        // client 3 both push- and pull-eligible: push must win
        rx_empty = 4'b0111;
        push_data[127:96] = 32'h33330003;
        push_req = 4'b1000;
        pull_req = 4'b1000;
        #1;
        n_checks++;
        if ({action, mindex, push_ack, din} !== {6'd4, 2'd3, 4'b1000, 32'h33330003}) begin
            n_fail++;
            $display("FAIL push_priority got act=%0d idx=%0d ack=%b din=%h expected 4/3/1000/33330003",
                     action, mindex, push_ack, din);
        end
        @(negedge clk);
        push_req = 4'b0000;
        pull_req = 4'b0000;
        rx_empty = 4'hF;
        @(negedge clk);
    endtask

    task automatic test_reload();
        reload = 1'b1;
        #1;
        n_checks++;
        if (loaded !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_before got loaded=%0d expected 1", loaded);
        end
        @(negedge clk);
        reload = 1'b0;
        test_load();
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout got hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 32; k++) begin
            prog_rom[k] = 16'hA000 + 16'(k);
            conf_rom[k] = '0;
        end
        for (int k = 0; k < 5; k++)
            conf_rom[k] = {2'(k), 4'(k + 2), 32'hC0F00000 | 32'(k)};
        n_reset   = 1'b0;
        reload    = 1'b0;
        dout      = '0;
        tx_full   = '0;
        rx_empty  = 4'hF;
        push_req  = '0;
        push_data = '0;
        pull_req  = '0;

        test_reset();
        test_mid_reset();
        test_load();
        test_round_robin();
        test_single_push();
        test_backpressure();
        test_pull();
        test_reload();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pio_sequencer.md
Name: pio_sequencer

Overview:
- Sits between the top level and one `pio` instance and owns its command bus (`action`/`din`/`index`/`mindex`).
- After reset it streams the instruction ROM and the configuration ROM into the PIO. It then enters a run phase.
- In the run phase it arbitrates TX pushes and RX pulls from up to four client requesters, one per state machine, using round-robin.
- It replaces ad-hoc load/push sequencing in top-level files.

Parameters:
- PROG_LEN, 32, instruction words loaded (1..32)
- CONF_LEN, 5, configuration entries issued (0..32)

Ports:
- clk  in  1  system clock
- n_reset  in  1  asynchronous active-low reset
- reload  in  1  pulse: restart the load sequence from the run phase
- prog_addr  out  5  instruction ROM address
- prog_data  in  16  instruction ROM data, valid 1 cycle after address
- conf_addr  out  5  config ROM address
- conf_data  in  38  config entry {mindex[37:36], action[35:32], din[31:0]}, 1-cycle latency
- action  out  6  PIO action
- din  out  32  PIO data
- index  out  5  PIO instruction index
- mindex  out  2  PIO machine index
- dout  in  32  PIO read data
- tx_full  in  4  per-SM TX FIFO full
- rx_empty  in  4  per-SM RX FIFO empty
- push_req  in  4  client i wants to push
- push_data  in  128  client i data at [32*i+31:32*i]
- push_ack  out  4  one-hot: push of client i issued this cycle
- pull_req  in  4  client i wants RX data
- pull_valid  out  4  one-hot: pull_data valid for client i
- pull_data  out  32  RX word
- loaded  out  1  high in the run phase

Behaviour:
- Package constants: ACT_NONE=0, ACT_INSTR=1, ACT_PUSH=4, ACT_PULL=5.
- Reset (async, n_reset=0) values:
  - action=0, din=0, index=0, mindex=0.
  - prog_addr=0, conf_addr=0.
  - push_ack=0, pull_valid=0, pull_data=0, loaded=0.
  - State=PROG, round-robin pointer=0.
- Reset is also allowed mid-operation: the sequence restarts at PROG, address 0.

State machine, one action per command cycle:
- PROG:
  - Address k is presented at cycle t; at t+1 the block drives action=ACT_INSTR, index=k, din={16'h0, prog_data}, mindex=0.
  - Addresses are pipelined, so one instruction is issued per cycle.
  - After word PROG_LEN-1 is issued, go to CONF, or to RUN if CONF_LEN=0.
- CONF:
  - Same 1-cycle pipelined read; drives action=conf_data[35:32], mindex=[37:36], din=[31:0], index=0.
  - After entry CONF_LEN-1 is issued, go to GAP with next=RUN.
- GAP:
  - One cycle with action=ACT_NONE, din held.
  - Then go to the next state; loaded rises on entry to RUN.
- RUN:
  - Eligible push client i: push_req[i] & ~tx_full[i].
  - Eligible pull client i: pull_req[i] & ~rx_empty[i].
  - Client i is eligible if either holds; push takes priority when both hold for the same i.
  - Round-robin grant among the four clients starts at the pointer; the pointer moves to grant+1 mod 4.
  - Push grant: action=ACT_PUSH, mindex=i, din=push_data slice, push_ack[i]=1 for exactly that cycle; go to GAP.
  - Pull grant: action=ACT_PULL, mindex=i; go to PULLW.
  - No eligible client: action=ACT_NONE.
- PULLW:
  - action=ACT_NONE; this cycle pull_data=dout and pull_valid[i]=1; go to RUN.
- Throughput: at most one transfer per 2 cycles in RUN.
- A client whose FIFO flag flips to full/empty while its request is pending is simply not granted. There is no error or timeout.
- reload:
  - Sampled only in RUN or GAP with next=RUN; ignored during PROG/CONF.
  - Sampled in RUN: it wins over any grant in that cycle; loaded drops next cycle and the block re-enters PROG at address 0.
  - Sampled in GAP: it is held pending and taken on the first RUN cycle.
- Counters are 6-bit so that PROG_LEN=32 terminates without wrap; addresses are the low 5 bits.

Decomposition:
- Shared package `pio_pkg`:
  - Action codes.
  - Conf field bit positions.
  - State enum: PROG, CONF, GAP, RUN, PULLW.
- One sub-module `rr_arb4`:
  - Inputs: 4-bit eligible vector and pointer.
  - Outputs: one-hot grant plus valid; combinational.
  - The pointer register lives in the parent.

Test Plan:
- Load:
  - Stimulus: PROG_LEN=32, ROM word k = 16'hA000+k, CONF_LEN=5; release reset.
  - Required: 32 consecutive cycles of action=1, index k, din=A000+k; then 5 conf actions matching the ROM; one ACT_NONE cycle; loaded=1 at cycle 39.
- Single push:
  - Stimulus: in RUN, push_req=4'b0001, data 32'h1, tx_full=0.
  - Required: action=4, mindex=0, din=1, push_ack=0001 for one cycle; next cycle action=0.
- Round-robin:
  - Stimulus: push_req=4'b1111 held, all FIFOs non-full.
  - Required: grants in the order 0,1,2,3,0, each 2 cycles apart, push_ack one-hot.
- Backpressure:
  - Stimulus: push_req[2]=1 with tx_full[2]=1 for 10 cycles.
  - Required: no ack and action stays 0; after tx_full[2] drops, ack within 2 cycles.
- Pull:
  - Stimulus: pull_req[1]=1, rx_empty[1]=0, dout=32'hDEADBEEF.
  - Required: action=5, mindex=1; next cycle pull_valid=0010, pull_data=DEADBEEF.
- Reset/reload:
  - Stimulus: assert n_reset low mid-PROG at index 10.
  - Required: all outputs 0 immediately (asynchronous); after release, load restarts at index 0.
  - Stimulus: reload pulse in RUN.
  - Required: loaded=0 next cycle and the full load repeats.
